logic_unit_arbiter: RTL

- Shares one 16-bit bitwise logic unit (AND/OR/XOR/NOT) among N_REQ requesters.
- Round-robin arbitration selects a requester. Its operands are captured, the result is computed through the shared unit and registered, and the tagged result is returned over a single valid/ready response channel.
- Sits between the CPU-side operation issuers and the And16-class gate datapath.

---
 rtl/logic_unit_arbiter.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin arbiter sharing one bitwise logic unit
// (AND/OR/XOR/NOT) among N_REQ requesters. One operation is in flight at a
// time: IDLE arbitrates and captures, EXEC computes, RESP holds the tagged
// result on the response channel until it is consumed.
// Optional feature macro LU_STATS_EN adds the stat_ops / stat_wait counters.
module logic_unit_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [2*N_REQ-1:0]     req_op,
    input  logic [WIDTH*N_REQ-1:0] req_a,
    input  logic [WIDTH*N_REQ-1:0] req_b,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] resp_id,
    output logic [WIDTH-1:0]       resp_data,
    output logic                   busy
`ifdef LU_STATS_EN
    ,
    output logic [15:0]            stat_ops,
    output logic [15:0]            stat_wait
`endif
);

    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Shared bitwise unit; NOT ignores b, results are exactly WIDTH bits.
    function automatic logic [WIDTH-1:0] lu_eval(input logic [1:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = a ^ b;
            2'b11:   r = ~a;
            default: r = '0;
        endcase
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [IDW-1:0]     id_q, id_d;
    logic               resp_valid_q, resp_valid_d;
    logic [IDW-1:0]     resp_id_q, resp_id_d;
    logic [WIDTH-1:0]   resp_data_q, resp_data_d;

    logic               grant_found_s;
    logic [IDW-1:0]     winner_s;
    logic [IDW-1:0]     cand_s;
    logic [IDW-1:0]     lowest_s;
    logic [1:0]         sel_op_s;
    logic [WIDTH-1:0]   sel_a_s, sel_b_s;

    // Round-robin search starting at rr_ptr, plus lowest-index valid requester.
    always_comb begin
        grant_found_s = 1'b0;
        winner_s      = '0;
        cand_s        = '0;
        lowest_s      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_s = IDW'((int'(rr_ptr_q) + k) % N_REQ);
            if (!grant_found_s && req_valid[cand_s]) begin
                grant_found_s = 1'b1;
                winner_s      = cand_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                lowest_s = IDW'(k);
            end else begin
                lowest_s = lowest_s;
            end
        end
    end

    // Operand mux for the current winner.
    always_comb begin
        sel_op_s = '0;
        sel_a_s  = '0;
        sel_b_s  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (winner_s == IDW'(k)) begin
                sel_op_s = req_op[2*k +: 2];
                sel_a_s  = req_a[WIDTH*k +: WIDTH];
                sel_b_s  = req_b[WIDTH*k +: WIDTH];
            end else begin
                sel_op_s = sel_op_s;
            end
        end
    end

    // Grant is combinational in IDLE only; forced low while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state_q == ST_IDLE) && grant_found_s) begin
            req_ready[winner_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state and datapath update for the IDLE/EXEC/RESP sequence.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_found_s) begin
                    op_d     = sel_op_s;
                    a_d      = sel_a_s;
                    b_d      = sel_b_s;
                    id_d     = winner_s;
                    rr_ptr_d = (winner_s == IDW'(N_REQ - 1)) ? '0 : winner_s + IDW'(1);
                    state_d  = ST_EXEC;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_EXEC: begin
                resp_data_d  = lu_eval(op_q, a_q, b_q);
                resp_id_d    = id_q;
                resp_valid_d = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    state_d      = ST_RESP;
                end
            end
            default: begin
                resp_valid_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // State, captured operands and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            op_q         <= 2'b00;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign busy       = (state_q != ST_IDLE);

`ifdef LU_STATS_EN
    logic [15:0] stat_ops_q;
    logic [15:0] stat_wait_q;

    // Completed-handshake counter (wraps) and fairness wait counter (saturates).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops_q  <= 16'h0000;
            stat_wait_q <= 16'h0000;
        end else begin
            if (resp_valid_q && resp_ready) begin
                stat_ops_q <= stat_ops_q + 16'h0001;
            end else begin
                stat_ops_q <= stat_ops_q;
            end
            if ((state_q == ST_IDLE) && grant_found_s && (winner_s != lowest_s) &&
                (stat_wait_q != 16'hFFFF)) begin
                stat_wait_q <= stat_wait_q + 16'h0001;
            end else begin
                stat_wait_q <= stat_wait_q;
            end
        end
    end

    assign stat_ops  = stat_ops_q;
    assign stat_wait = stat_wait_q;
`endif

endmodule
